// File: rtl/aximm_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : aximm_burst_engine
//  Description : AXI4 write-burst traffic generator. Issues cfg_burst_count
//                INCR bursts of cfg_burst_bytes each, at cfg_addr + k*stride,
//                with a deterministic data pattern. AW and W run decoupled,
//                outstanding bursts are bounded, B responses are counted.
//  Ports       : clk/reset            - clock, async active-high reset
//                start, cfg_*         - run control (latched on start)
//                busy/done/cfg_err    - run status
//                resp_errs            - non-OKAY B responses this run
//                M_AXI_AW*/W*/B*      - AXI4 write master channels
//  Revision    : 1.0 - initial release
// ============================================================================
module aximm_burst_engine #(
    parameter int DATA_WBITS      = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [63:0]               cfg_addr,
    input  logic [15:0]               cfg_burst_bytes,
    input  logic [31:0]               cfg_burst_count,
    input  logic [31:0]               cfg_stride,
    input  logic                      cfg_mode,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err,
    output logic [31:0]               resp_errs,
    output logic [63:0]               M_AXI_AWADDR,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WBITS-1:0]     M_AXI_WDATA,
    output logic [DATA_WBITS/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);

    localparam int DATA_WBYTS  = DATA_WBITS / 8;
    localparam int c_SIZE_LOG2 = $clog2(DATA_WBYTS);
    localparam int c_LANES     = DATA_WBITS / 32;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state, w_state_next;

    // latched run configuration
    logic [63:0]            r_next_addr;
    logic [31:0]            r_stride;
    logic [31:0]            r_count;
    logic [8:0]             r_beats;
    logic [c_SIZE_LOG2-1:0] r_extra;
    logic                   r_mode;

    // progress counters
    logic [31:0]            r_aw_issued;
    logic [31:0]            r_b_received;
    logic [31:0]            r_wb;        // burst of the next beat to load
    logic [8:0]             r_wj;        // beat index (1-based) of the next beat to load

    // registered outputs
    logic                   r_done, r_cfg_err;
    logic [31:0]            r_resp_errs;
    logic [63:0]            r_awaddr;
    logic [7:0]             r_awlen;
    logic                   r_awvalid;
    logic [DATA_WBITS-1:0]  r_wdata;
    logic [DATA_WBYTS-1:0]  r_wstrb;
    logic                   r_wlast, r_wvalid;

    logic [16:0]            w_beats_calc;
    logic                   w_cfg_bad, w_start_acc, w_run_go, w_run_end;
    logic                   w_aw_can, w_w_load, w_last_beat;
    logic [31:0]            w_b_next, w_pattern;
    logic [DATA_WBITS-1:0]  w_wdata_fmt;
    logic [DATA_WBYTS-1:0]  w_wstrb_fmt;

    assign w_beats_calc = ({1'b0, cfg_burst_bytes} + 17'(DATA_WBYTS - 1)) >> c_SIZE_LOG2;
    assign w_cfg_bad    = (cfg_burst_bytes == 16'd0) || (w_beats_calc > 17'd256);
    assign w_start_acc  = (r_state == S_IDLE) && start;
    assign w_run_go     = w_start_acc && !w_cfg_bad && (cfg_burst_count != 32'd0);
    assign w_b_next     = r_b_received + 32'd1;
    // done lands in the cycle after the final B handshake
    assign w_run_end    = (r_state == S_RUN) && M_AXI_BVALID && (w_b_next == r_count);

    // outstanding bound uses registered counts; B only ever lowers it, so this is safe
    assign w_aw_can     = (r_aw_issued < r_count) &&
                          ((r_aw_issued - r_b_received) < 32'(MAX_OUTSTANDING));
    // a beat may only be loaded once its burst's AW has completed its handshake
    assign w_w_load     = (!r_wvalid || M_AXI_WREADY) && (r_wb < r_aw_issued);
    assign w_last_beat  = (r_wj == r_beats);
    assign w_pattern    = (r_wb << 8) | {23'd0, r_wj};

    always_comb begin
        w_wdata_fmt = '0;
        w_wstrb_fmt = '1;
        if (r_mode) begin
            w_wdata_fmt = {c_LANES{w_pattern}};
        end else begin
            w_wdata_fmt = DATA_WBITS'(w_pattern);
        end
        if (w_last_beat && (r_extra != '0)) begin
            w_wstrb_fmt = ~({DATA_WBYTS{1'b1}} << r_extra);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_run_go)  w_state_next = S_RUN;
            S_RUN:   if (w_run_end) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_next_addr  <= '0;
            r_stride     <= '0;
            r_count      <= '0;
            r_beats      <= '0;
            r_extra      <= '0;
            r_mode       <= 1'b0;
            r_aw_issued  <= '0;
            r_b_received <= '0;
            r_wb         <= '0;
            r_wj         <= '0;
            r_done       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_resp_errs  <= '0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_awvalid    <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_wlast      <= 1'b0;
            r_wvalid     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_acc) begin
                r_cfg_err    <= w_cfg_bad;
                r_resp_errs  <= '0;
                // rejected or empty runs complete immediately with no traffic
                r_done       <= w_cfg_bad || (cfg_burst_count == 32'd0);
                r_next_addr  <= cfg_addr;
                r_stride     <= cfg_stride;
                r_count      <= cfg_burst_count;
                r_beats      <= w_beats_calc[8:0];
                r_extra      <= cfg_burst_bytes[c_SIZE_LOG2-1:0];
                r_mode       <= cfg_mode;
                r_awlen      <= 8'(w_beats_calc - 17'd1);
                r_aw_issued  <= '0;
                r_b_received <= '0;
                r_wb         <= '0;
                r_wj         <= 9'd1;
            end else if (r_state == S_RUN) begin
                // AW issuer
                if (r_awvalid) begin
                    if (M_AXI_AWREADY) begin
                        r_awvalid   <= 1'b0;
                        r_aw_issued <= r_aw_issued + 32'd1;
                        r_next_addr <= r_next_addr + {32'd0, r_stride};
                    end
                end else if (w_aw_can) begin
                    r_awvalid <= 1'b1;
                    r_awaddr  <= r_next_addr;
                end
                // W issuer
                if (w_w_load) begin
                    r_wvalid <= 1'b1;
                    r_wdata  <= w_wdata_fmt;
                    r_wstrb  <= w_wstrb_fmt;
                    r_wlast  <= w_last_beat;
                    if (w_last_beat) begin
                        r_wb <= r_wb + 32'd1;
                        r_wj <= 9'd1;
                    end else begin
                        r_wj <= r_wj + 9'd1;
                    end
                end else if (r_wvalid && M_AXI_WREADY) begin
                    r_wvalid <= 1'b0;
                end
                // B tracking
                if (M_AXI_BVALID) begin
                    r_b_received <= w_b_next;
                    if ((M_AXI_BRESP != 2'b00) && (r_resp_errs != 32'hFFFF_FFFF)) begin
                        r_resp_errs <= r_resp_errs + 32'd1;
                    end
                end
                if (w_run_end) r_done <= 1'b1;
            end
        end
    end

    assign busy          = (r_state == S_RUN);
    assign done          = r_done;
    assign cfg_err       = r_cfg_err;
    assign resp_errs     = r_resp_errs;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWLEN   = r_awlen;
    assign M_AXI_AWSIZE  = 3'(c_SIZE_LOG2);
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WLAST   = r_wlast & r_wvalid;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_aximm_burst_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aximm_burst_engine
//  Description : Self-checking bench for aximm_burst_engine. A randomised
//                slave drives ready/B; a monitor compares every handshake
//                with a reference computed from burst arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aximm_burst_engine;

    localparam int DW   = 512;
    localparam int DB   = DW / 8;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   cfg_addr;
    logic [15:0]   cfg_burst_bytes;
    logic [31:0]   cfg_burst_count;
    logic [31:0]   cfg_stride;
    logic          cfg_mode;
    logic          busy, done, cfg_err;
    logic [31:0]   resp_errs;
    logic [63:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [DB-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;

    always #5 clk = ~clk;

    aximm_burst_engine #(.DATA_WBITS(DW), .MAX_OUTSTANDING(MAXO)) u_dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_addr(cfg_addr), .cfg_burst_bytes(cfg_burst_bytes),
        .cfg_burst_count(cfg_burst_count), .cfg_stride(cfg_stride), .cfg_mode(cfg_mode),
        .busy(busy), .done(done), .cfg_err(cfg_err), .resp_errs(resp_errs),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // current run description
    logic [63:0] c_addr;
    logic [31:0] c_stride;
    int          c_bytes, c_count, c_beats, c_extra;
    bit          c_mode;

    // slave controls / state
    bit rnd_ready = 1'b0;
    int b_allow   = 1 << 30;
    int err_idx   = -1;
    int b_sent    = 0;
    int aw_st     = 0;
    int w_st      = 0;

    // monitor / reference state
    bit          mon_en = 1'b0;
    int          aw_k = 0, w_b = 0, w_j = 1, b_cnt = 0, wlast_cnt = 0;
    bit          exp_done_next = 1'b0;
    bit          prev_w_stall = 1'b0;
    logic [DW-1:0] prev_wdata;

    function automatic logic [DW-1:0] exp_data(input int b, input int j, input bit md);
        logic [31:0]   p;
        logic [DW-1:0] r;
        p = (32'(b) << 8) | 32'(j);
        r = '0;
        if (md) begin
            for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = p;
        end else begin
            r[31:0] = p;
        end
        return r;
    endfunction

    function automatic logic [DB-1:0] exp_strb(input int j);
        logic [DB-1:0] s;
        s = '1;
        if (j == c_beats && c_extra != 0) s = (64'h1 << c_extra) - 64'h1;
        return s;
    endfunction

    // slave: ready stalls of 0..5 cycles, B one per completed burst
    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(posedge clk); #1;
            if (rnd_ready) begin
                awready = (aw_st == 0);
                aw_st   = (aw_st == 0) ? int'($urandom_range(0, 5)) : aw_st - 1;
                wready  = (w_st == 0);
                w_st    = (w_st == 0) ? int'($urandom_range(0, 5)) : w_st - 1;
            end else begin
                awready = 1'b1;
                wready  = 1'b1;
            end
            if (!reset && b_sent < wlast_cnt && b_sent < b_allow &&
                (!rnd_ready || $urandom_range(0, 1) == 1)) begin
                bvalid = 1'b1;
                bresp  = (b_sent == err_idx) ? 2'b10 : 2'b00;
                b_sent++;
            end else begin
                bvalid = 1'b0;
                bresp  = 2'b00;
            end
        end
    end

    // reference monitor
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("done", done, exp_done_next);
            exp_done_next = 1'b0;
            if (prev_w_stall) begin
                chk("w_hold_valid", wvalid, 1'b1);
                chk("w_hold_data", wdata, prev_wdata);
            end
            if (wvalid) begin
                chk("w_after_aw", w_b < aw_k, 1'b1);
                if (wready) begin
                    chk("wdata", wdata, exp_data(w_b, w_j, c_mode));
                    chk("wstrb", wstrb, exp_strb(w_j));
                    chk("wlast", wlast, w_j == c_beats);
                    if (w_j == c_beats) begin
                        w_b++; w_j = 1; wlast_cnt++;
                    end else begin
                        w_j++;
                    end
                end
            end
            prev_w_stall = wvalid && !wready;
            prev_wdata   = wdata;
            if (awvalid && awready) begin
                chk("awaddr", awaddr, c_addr + 64'(aw_k) * {32'd0, c_stride});
                chk("awlen", awlen, c_beats - 1);
                chk("outstanding", (aw_k - b_cnt) < MAXO, 1'b1);
                aw_k++;
            end
            if (bvalid) begin
                b_cnt++;
                if (b_cnt == c_count) exp_done_next = 1'b1;
            end
        end
    end

    task automatic start_run(input logic [63:0] a, input int bytes, input int cnt,
                             input logic [31:0] st, input bit md, input bit rr, input int eidx);
        c_addr = a; c_bytes = bytes; c_count = cnt; c_stride = st; c_mode = md;
        c_beats = (bytes + DB - 1) / DB; c_extra = bytes % DB;
        rnd_ready = rr; err_idx = eidx;
        aw_k = 0; w_b = 0; w_j = 1; b_cnt = 0; wlast_cnt = 0; b_sent = 0;
        exp_done_next = 1'b0; prev_w_stall = 1'b0;
        cfg_addr = a; cfg_burst_bytes = 16'(bytes); cfg_burst_count = 32'(cnt);
        cfg_stride = st; cfg_mode = md;
        @(posedge clk); #1;
        start = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic finish_run(input int exp_errs);
        int t;
        t = 0;
        while (!done && t < 4000) begin
            @(negedge clk); #1;
            t++;
        end
        chk("run_timeout", t < 4000, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        chk("aw_count", aw_k, c_count);
        chk("w_bursts", w_b, c_count);
        chk("b_count", b_cnt, c_count);
        chk("resp_errs", resp_errs, exp_errs);
        chk("cfg_err_run", cfg_err, 1'b0);
        @(negedge clk); #1;
        mon_en = 1'b0;
        b_allow = 1 << 30;
    endtask

    task automatic quick_cfg(input int bytes, input int cnt, input bit exp_err);
        cfg_addr = 64'h2000; cfg_burst_bytes = 16'(bytes); cfg_burst_count = 32'(cnt);
        cfg_stride = 32'h40; cfg_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("quick_done", done, 1'b1);
        chk("quick_cfg_err", cfg_err, exp_err);
        chk("quick_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            chk("quick_no_aw", awvalid, 1'b0);
            @(posedge clk); #1;
        end
        chk("quick_done_pulse", done, 1'b0);
    endtask

    initial begin
        int t;
        start = 1'b0; reset = 1'b0;
        cfg_addr = '0; cfg_burst_bytes = '0; cfg_burst_count = '0; cfg_stride = '0; cfg_mode = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_cfg_err", cfg_err, 1'b0);
        chk("rst_resp_errs", resp_errs, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_awlen", awlen, 0);
        chk("awsize", awsize, 3'd6);
        chk("awburst", awburst, 2'b01);
        chk("bready", bready, 1'b1);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;

        // basic three-burst run, partial last beat
        start_run(64'h1000, 100, 3, 32'h100, 1'b0, 1'b0, -1);
        finish_run(0);

        // outstanding bound with B withheld
        b_allow = 0;
        start_run(64'h0, 64, 5, 32'h40, 1'b0, 1'b0, -1);
        repeat (20) begin @(negedge clk); #1; end
        chk("t2_aw", aw_k, 2);
        chk("t2_w", w_b, 2);
        chk("t2_awvalid", awvalid, 1'b0);
        chk("t2_busy", busy, 1'b1);
        b_allow = 1;
        repeat (10) begin @(negedge clk); #1; end
        chk("t2_aw_after_b", aw_k, 3);
        b_allow = 1 << 30;
        finish_run(0);

        // rejected and empty configurations
        quick_cfg(0, 3, 1'b1);
        quick_cfg(16385, 3, 1'b1);
        quick_cfg(64, 0, 1'b0);

        // error response on second B
        start_run(64'h8000, 64, 4, 32'h40, 1'b0, 1'b0, 1);
        finish_run(1);

        // stalls, replicated pattern
        start_run({$urandom, $urandom}, 200, 20, $urandom, 1'b1, 1'b1, -1);
        finish_run(0);

        // a few random runs
        for (int r = 0; r < 4; r++) begin
            start_run({$urandom, $urandom}, int'($urandom_range(1, 700)), int'($urandom_range(1, 6)),
                      $urandom, 1'($urandom_range(0, 1)), 1'b1, int'($urandom_range(0, 5)));
            finish_run((err_idx < c_count) ? 1 : 0);
        end

        // reset in the middle of a run, then a clean rerun
        start_run(64'h4000, 200, 3, 32'h200, 1'b0, 1'b0, -1);
        t = 0;
        while (wlast_cnt == 0 && w_j == 1 && t < 200) begin
            @(negedge clk); #1;
            t++;
        end
        chk("t6_first_beat_timeout", t < 200, 1'b1);
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_awvalid", awvalid, 1'b0);
        chk("t6_wvalid", wvalid, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_done", done, 1'b0);
        chk("t6_awaddr", awaddr, 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        start_run(64'h4000, 200, 3, 32'h200, 1'b0, 1'b0, -1);
        finish_run(0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
